// File: rtl/axis_router_if.sv
// AXI-Stream link bundle shared by the router's ingress and egress ports.
interface axis_router_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tdest;

  // Source side: drives the payload, observes ready.
  modport master (output tdata, output tvalid, output tlast, output tdest, input tready);
  // Sink side: observes the payload, drives ready.
  modport slave  (input tdata, input tvalid, input tlast, input tdest, output tready);
endinterface

// File: rtl/axis_router.sv
// 1:2 AXI-Stream packet router: whole packets are steered to port A or B by the
// tdest of their first beat, through a 2-entry ingress buffer and per-port output registers.
module axis_router #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  axis_router_if.slave         s0,
  axis_router_if.master        m0a,
  axis_router_if.master        m0b,
  output logic [CNT_WIDTH-1:0] pkt_cnt_a,
  output logic [CNT_WIDTH-1:0] pkt_cnt_b
);

  typedef struct packed {
    logic                  tdest;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } beat_t;

  typedef enum logic [1:0] {
    ST_SOP,
    ST_LOCK_A,
    ST_LOCK_B
  } state_t;

  state_t                state_q, state_d;
  beat_t                 buf_q [2];
  beat_t                 buf_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  a_valid_q, a_valid_d;
  logic                  b_valid_q, b_valid_d;
  beat_t                 a_beat_q, a_beat_d;
  beat_t                 b_beat_q, b_beat_d;
  logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d;

  beat_t                 head;
  logic                  head_valid;
  logic                  head_to_b;
  logic                  a_free;
  logic                  b_free;
  logic                  push;
  logic                  pop;

  // Routing decision, buffer bookkeeping, output register loads and packet FSM.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    a_beat_d   = a_beat_q;
    b_beat_d   = b_beat_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;

    head       = buf_q[rd_ptr_q];
    head_valid = (count_q != 2'd0);
    push       = s0.tvalid && s_ready_q;
    a_free     = !a_valid_q || m0a.tready;
    b_free     = !b_valid_q || m0b.tready;

    // Locked states ignore tdest on continuation beats.
    case (state_q)
      ST_LOCK_A: head_to_b = 1'b0;
      ST_LOCK_B: head_to_b = 1'b1;
      default:   head_to_b = head.tdest;
    endcase

    // Head-of-line: only the head may move, and only into its own port.
    pop = head_valid && (head_to_b ? b_free : a_free);

    if (push) begin
      buf_d[wr_ptr_q] = '{tdest: s0.tdest, tlast: s0.tlast, tdata: s0.tdata};
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d   = count_q + 2'(push) - 2'(pop);
    s_ready_d = (count_d < 2'd2);

    if (m0a.tready) begin
      a_valid_d = 1'b0;
    end
    if (m0b.tready) begin
      b_valid_d = 1'b0;
    end
    if (pop && !head_to_b) begin
      a_valid_d = 1'b1;
      a_beat_d  = '{tdest: 1'b0, tlast: head.tlast, tdata: head.tdata};
    end
    if (pop && head_to_b) begin
      b_valid_d = 1'b1;
      b_beat_d  = '{tdest: 1'b1, tlast: head.tlast, tdata: head.tdata};
    end

    if (pop) begin
      case (state_q)
        ST_SOP: begin
          if (!head.tlast) begin
            state_d = head.tdest ? ST_LOCK_B : ST_LOCK_A;
          end
        end
        default: begin
          if (head.tlast) begin
            state_d = ST_SOP;
          end
        end
      endcase
    end

    if (a_valid_q && m0a.tready && a_beat_q.tlast) begin
      cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
    end
    if (b_valid_q && m0b.tready && b_beat_q.tlast) begin
      cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
    end
  end

  // State, buffer and output registers; reset discards any buffered beats.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= ST_SOP;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      s_ready_q <= 1'b0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_beat_q  <= '0;
      b_beat_q  <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_beat_q  <= a_beat_d;
      b_beat_q  <= b_beat_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
    end
  end

  assign s0.tready  = s_ready_q;
  assign m0a.tvalid = a_valid_q;
  assign m0a.tdata  = a_beat_q.tdata;
  assign m0a.tlast  = a_beat_q.tlast;
  assign m0a.tdest  = a_beat_q.tdest;
  assign m0b.tvalid = b_valid_q;
  assign m0b.tdata  = b_beat_q.tdata;
  assign m0b.tlast  = b_beat_q.tlast;
  assign m0b.tdest  = b_beat_q.tdest;
  assign pkt_cnt_a  = cnt_a_q;
  assign pkt_cnt_b  = cnt_b_q;

endmodule
